dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words; a power of two, 4..4096.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra cycles between request accept and response; range 0..15.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data.
REQ-010 SHALL have port req_wstrb, input, 4, byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid, output, 1, response available.
REQ-012 SHALL have port resp_ready, input, 1, initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32, load data.
REQ-014 SHALL have port resp_err, output, 1, request faulted.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a clk edge with req_valid && req_ready, latching write, addr, wdata and wstrb; inputs are ignored outside acceptance.
REQ-017 SHALL transition on accept from IDLE to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES>0, else directly to RESP.
REQ-018 SHALL decrement the counter in WAIT and go to RESP on the edge where counter == 0.
REQ-019 SHALL assert resp_valid exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-020 SHALL flag error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-021 SHALL commit a store on the edge entering RESP, writing only strobed bytes; a faulted store writes nothing.
REQ-022 SHALL capture load data from word addr[31:2] on the edge entering RESP.
REQ-023 SHALL drive resp_rdata = 0 for stores and faulted requests.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then go to IDLE on that edge.
REQ-025 SHALL deassert resp_valid and assert req_ready in the cycle after the response handshake, giving a 2+WAIT_CYCLES cycle minimum request period.
REQ-026 SHALL complete a store with wstrb = 0 without error, leaving memory unchanged.
REQ-027 SHALL ignore req_valid asserted in WAIT or RESP; the request stays pending until IDLE.

Reset
REQ-028 SHALL force state IDLE, counter 0, resp_valid 0, resp_err 0 and resp_rdata 0 while rst = 0, independent of clk.
REQ-029 SHALL abort an in-flight request on reset without committing its store; reset does not clear storage contents.
REQ-030 SHALL drive req_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the state encoding (IDLE/WAIT/RESP), the data width (32) and the strobe width (4) in shared package dmem_pkg.
REQ-032 SHALL isolate storage in sub-module dmem_array: one synchronous write port with byte enables and one read port.

Verification
REQ-033 SHALL test: WAIT_CYCLES=2, store addr 0x10, data 0xDEADBEEF, wstrb 0xF, resp_ready=1, then load 0x10 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL test: store 0x11223344 to 0x20 with wstrb 0xF, then store 0x000000AA to 0x20 with wstrb 0x1, then load -> 0x112233AA.
REQ-035 SHALL test: load 0x22 (misaligned) and load 4*DEPTH_WORDS (out of range) -> err 1, rdata 0; a faulted store leaves the target word unchanged.
REQ-036 SHALL test: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready 0; handshake -> req_ready 1 on the next cycle.
REQ-037 SHALL test: WAIT_CYCLES=0, back-to-back loads -> resp_valid 1 cycle after each accept, accepts 2 cycles apart.
REQ-038 SHALL test: assert rst low during WAIT of a store to 0x30 -> outputs reset immediately, word 0x30 keeps its old value, req_ready 1 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM encoding
// and the byte-strobe expansion used by the storage array.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one byte-enabled synchronous write port and one
// combinational read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] wmask;

    assign wmask = strb_mask(wstrb);

    // NOTE: storage has no reset; contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, waits
// WAIT_CYCLES, then presents a held response until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    logic [3:0]        cnt;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic              cur_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero wait cycles the response is formed on the accept edge itself,
    // so the live request is used before it has been latched.
    assign cur_write = (state == IDLE) ? req_write : write_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

    // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
    assign cur_err = (|cur_addr[1:0]) || (|cur_addr[31:AW+2]);

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
    assign mem_we     = enter_resp && cur_write && !cur_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(cur_addr[AW+1:2]),
        .wdata(cur_wdata),
        .wstrb(cur_wstrb),
        .raddr(cur_addr[AW+1:2]),
        .rdata(mem_rdata)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= cur_err;
                resp_rdata <= (cur_write || cur_err) ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives two responders (WAIT_CYCLES=0, DEPTH 16 and WAIT_CYCLES=2, DEPTH 256)
// against a word-array reference model of the memory and the timing rules.
module tb_dmem_responder;

    localparam int PERIOD = 10;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wstrb  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    logic [31:0] model [2][256];
    bit          known [2][256];

    int          n_checks = 0;
    int          n_pass   = 0;
    time         accept_time;
    logic [31:0] last_rdata;

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 256;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // One complete transaction; entered and left just after a falling edge.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int hold, input string tag);
        bit          exp_err;
        bit          check_data;
        logic [31:0] exp_rdata;
        int          widx;
        int          wt;
        int          lat;
        exp_err    = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth_of(d)));
        widx       = exp_err ? 0 : int'(addr >> 2);
        exp_rdata  = (wr || exp_err) ? 32'h0 : model[d][widx];
        check_data = wr || exp_err || known[d][widx];

        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
        wt = 0;
        while (req_ready[d] !== 1'b1 && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        n_checks++;
        if (wt >= 20) $display("FAIL %s accept: still not ready after %0d cycles, limit 20", tag, wt);
        else n_pass++;
        accept_time = $time;

        // Junk on the request bus, possibly still valid, must be ignored until IDLE.
        @(negedge clk);
        req_valid[d] = 1'($urandom_range(0, 1));
        req_write[d] = 1'($urandom_range(0, 1));
        req_addr[d]  = 32'($urandom_range(0, 15)) << 2;
        req_wdata[d] = $urandom;
        req_wstrb[d] = 4'($urandom);
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 1 + wait_of(d)) $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, 1 + wait_of(d));
        else n_pass++;
        n_checks++;
        if (resp_err[d] !== exp_err) $display("FAIL %s err: got %b, expected %b", tag, resp_err[d], exp_err);
        else n_pass++;
        if (check_data) begin
            n_checks++;
            if (resp_rdata[d] !== exp_rdata) $display("FAIL %s rdata: got %h, expected %h", tag, resp_rdata[d], exp_rdata);
            else n_pass++;
        end
        last_rdata = resp_rdata[d];

        if (wr && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[d][widx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (strb == 4'hF) known[d][widx] = 1'b1;
        end

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || resp_rdata[d] !== last_rdata || resp_err[d] !== exp_err)
                $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h err=%b, expected valid=1 ready=0 rdata=%h err=%b",
                         tag, h, resp_valid[d], req_ready[d], resp_rdata[d], resp_err[d], last_rdata, exp_err);
            else n_pass++;
        end

        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        req_valid[d]  = 1'b0;
        n_checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1)
            $display("FAIL %s release: valid=%b ready=%b, expected valid=0 ready=1", tag, resp_valid[d], req_ready[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d]        = 1'b0;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_wstrb[d]  = '0;
            resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (resp_valid[d] !== 1'b0 || resp_err[d] !== 1'b0 || resp_rdata[d] !== 32'h0)
                $display("FAIL reset%0d outputs: valid=%b err=%b rdata=%h, expected 0 0 0", d, resp_valid[d], resp_err[d], resp_rdata[d]);
            else n_pass++;
            rst[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1) $display("FAIL reset%0d ready: got %b, expected 1", d, req_ready[d]);
            else n_pass++;
        end
    endtask

    task automatic test_store_load();
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "sl_store");
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, "sl_load");
        n_checks++;
        if (last_rdata !== 32'hDEADBEEF) $display("FAIL sl_value: got %h, expected deadbeef", last_rdata);
        else n_pass++;
    endtask

    task automatic test_byte_strobe();
        txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "bs_full");
        txn(1, 1'b1, 32'h20, 32'h000000AA, 4'h1, 0, "bs_byte0");
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, "bs_load");
        n_checks++;
        if (last_rdata !== 32'h112233AA) $display("FAIL bs_value: got %h, expected 112233aa", last_rdata);
        else n_pass++;
        txn(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, "bs_nostrb");
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, "bs_nostrb_load");
    endtask

    task automatic test_faults();
        txn(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, "ft_init0");
        txn(1, 1'b0, 32'h22, 32'h0, 4'h0, 0, "ft_misaligned");
        txn(1, 1'b0, 32'h400, 32'h0, 4'h0, 0, "ft_range");
        txn(1, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, "ft_store_mis");
        txn(1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, "ft_store_range");
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ft_check20");
        txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, "ft_check0");
    endtask

    task automatic test_backpressure();
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, "bp_load");
        txn(0, 1'b1, 32'h4, 32'h5A5A1234, 4'hF, 5, "bp_store_w0");
    endtask

    task automatic test_back_to_back();
        time t_first;
        txn(0, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 0, "bb_init_a");
        txn(0, 1'b1, 32'hC, 32'h3C3C3C3C, 4'hF, 0, "bb_init_b");
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, "bb_load_a");
        t_first = accept_time;
        txn(0, 1'b0, 32'hC, 32'h0, 4'h0, 0, "bb_load_b");
        n_checks++;
        if (accept_time - t_first != 2 * PERIOD)
            $display("FAIL bb_spacing: accepts %0t apart, expected %0t", accept_time - t_first, 2 * PERIOD);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, "rw_init");
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h30;
        req_wdata[1] = 32'h12345678;
        req_wstrb[1] = 4'hF;
        @(negedge clk);
        req_valid[1] = 1'b0;
        n_checks++;
        if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0)
            $display("FAIL rw_inwait: ready=%b valid=%b, expected 0 0", req_ready[1], resp_valid[1]);
        else n_pass++;
        rst[1] = 1'b0;
        #1;
        n_checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || resp_err[1] !== 1'b0 || resp_rdata[1] !== 32'h0)
            $display("FAIL rw_async: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0",
                     req_ready[1], resp_valid[1], resp_err[1], resp_rdata[1]);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready[1] !== 1'b1) $display("FAIL rw_release: ready=%b, expected 1", req_ready[1]);
        else n_pass++;
        txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 0, "rw_load");
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                txn(d, 1'b1, 32'(w) << 2, $urandom, 4'hF, 0, "rnd_init");
            end
            for (int n = 0; n < 30; n++) begin
                int          r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 7)) << 2;
                if (r == 0) a = a | 32'($urandom_range(1, 3));
                else if (r == 1) a = a + 32'(4 * depth_of(d));
                txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), "rnd");
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_strobe();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
